demux1to4_stream_ctrl: RTL and testbench
========================================

Name: demux1to4_stream_ctrl

Overview:
- Sequencing controller for the 1-to-4 demultiplexer datapath.
- Accepts one valid/ready input stream and steers each accepted beat to one of four output channels.
- Channel choice is either an explicit per-beat destination (addressed mode) or a strict round-robin pointer (distribute mode).
- Each output channel has a one-entry holding register with its own valid/ready handshake, so one stalled consumer only blocks beats aimed at it.

Parameters:
- DATA_W, 8, width of the data payload per beat.
- CNT_W, 16, width of the accepted-beat counter (wraps modulo 2^CNT_W).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
- mode  input  1  0 = addressed (use in_dest), 1 = round-robin distribute.
- in_valid  input  1  input beat present.
- in_ready  output  1  controller can accept the beat this cycle.
- in_data  input  DATA_W  input payload.
- in_dest  input  2  destination channel (addressed mode only).
- out_valid  output  4  per-channel holding register full; bit k = channel k.
- out_ready  input  4  per-channel consumer ready.
- out_data0..out_data3  output  DATA_W each  per-channel payload.
- rr_ptr  output  2  next channel in round-robin mode.
- beat_cnt  output  CNT_W  total beats accepted since reset.

Behaviour:
- Reset: clk and rst are the only clock/reset. When rst=1 at a rising edge:
  - out_valid=4'b0000, all out_dataN=0, rr_ptr=0, beat_cnt=0.
  - Any buffered beats are discarded; in_ready is 0 during that cycle.
- Target channel T = (mode ? rr_ptr : in_dest), evaluated combinationally each cycle.
- in_ready = !rst && (!out_valid[T] || out_ready[T]).
  - in_ready is combinational from mode, in_dest, rr_ptr, out_valid and out_ready.
  - It never depends on in_valid.
- Accept condition: in_valid && in_ready. On accept:
  - out_dataT <= in_data; out_valid[T] <= 1.
  - beat_cnt <= beat_cnt + 1 (wraps to 0 after 2^CNT_W-1).
  - If mode=1, rr_ptr <= rr_ptr + 1 mod 4 (3 wraps to 0).
- Output handshake per channel k: when out_valid[k] && out_ready[k] and no accept targets k in the same cycle, out_valid[k] <= 0. out_datak holds its last value.
- Simultaneous drain and refill on the same channel (out_valid[T]=1, out_ready[T]=1, accept):
  - out_dataT takes the new beat and out_valid[T] stays 1.
  - Zero-bubble throughput: 1 beat/cycle per channel.
- Drains on other channels proceed independently in the same cycle. Up to 4 drains plus 1 accept per cycle.
- Latency: an accepted beat is visible on out_validT/out_dataT one cycle after acceptance.
- Round-robin is strict in-order: if channel rr_ptr is full and not draining, in_ready=0. No skipping to a free channel, so beat order across channels is deterministic.
- rr_ptr does not change in addressed mode. Switching mode takes effect the same cycle; rr_ptr keeps its value across switches.
- Stability rule: while in_valid=1 and in_ready=0, the upstream source holds in_data and in_dest stable. The controller does not latch them.
- No data path from out_ready back to out_data; outputs are registered.

Test Plan:
- Reset then addressed mode: beats 0x11,0x22,0x33,0x44 with in_dest 0,1,2,3, all out_ready=1 -> one cycle after each accept, out_valid shows 0001,0010,0100,1000; out_data0..3 = 11,22,33,44; beat_cnt=4.
- Backpressure: addressed mode, in_dest=2, out_ready=0000, send 0xA5 then 0x5A.
  - 0xA5 accepted; in_ready=0 for 0x5A; out_data2 stays A5.
  - Raise out_ready[2] -> 0x5A accepted that cycle; out_valid[2] stays 1, out_data2=5A next cycle.
- Round-robin: mode=1, out_ready=1111, stream 8 beats 0x01..0x08 -> channels 0,1,2,3,0,1,2,3 receive them in order; rr_ptr returns to 0; beat_cnt=8; in_ready=1 every cycle.
- Round-robin stall: mode=1, out_ready[1]=0, others 1, channel 1 already full -> beat aimed at channel 1 stalls (in_ready=0) and rr_ptr holds 1. Release out_ready[1] -> accepted, rr_ptr=2.
- Reset mid-operation: with out_valid=1111 and beat_cnt=9, assert rst for one cycle -> out_valid=0000, out_data all 0, rr_ptr=0, beat_cnt=0, in_ready=0 during rst.
- Counter wrap: CNT_W=4, accept 17 beats -> beat_cnt reads 15 after the 15th beat, 0 after the 16th, 1 after the 17th.

Source files
------------

// File: rtl/demux1to4_stream_ctrl.sv
// demux1to4_stream_ctrl
// Steers one valid/ready input stream onto four output channels. Each
// channel owns a one-entry holding register with its own handshake, so a
// stalled consumer only blocks beats aimed at that channel. The target is
// either the per-beat in_dest (addressed mode) or a strict in-order
// round-robin pointer (distribute mode).
module demux1to4_stream_ctrl #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_dest,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic [DATA_W-1:0] out_data0,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic [DATA_W-1:0] out_data3,
    output logic [1:0]        rr_ptr,
    output logic [CNT_W-1:0]  beat_cnt
);

    // Channel selection: round-robin pointer in distribute mode,
    // explicit destination otherwise.
    function automatic logic [1:0] sel_target(input logic       m,
                                              input logic [1:0] ptr,
                                              input logic [1:0] dest);
        return m ? ptr : dest;
    endfunction

    // Pointer advance; the 2-bit width gives the 3 -> 0 wrap for free.
    function automatic logic [1:0] next_ptr(input logic [1:0] ptr);
        return ptr + 2'd1;
    endfunction

    logic [3:0]        valid_q, valid_d;
    logic [DATA_W-1:0] data_q [4];
    logic [DATA_W-1:0] data_d [4];
    logic [1:0]        rr_q, rr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [1:0]        tgt;
    logic              accept;

    // Target channel and input handshake. A full channel still accepts when
    // it drains in the same cycle, giving one beat per cycle per channel.
    // Strict round-robin: no skipping past a blocked channel.
    always_comb begin
        tgt      = sel_target(mode, rr_q, in_dest);
        in_ready = !rst && (!valid_q[tgt] || out_ready[tgt]);
        accept   = in_valid && in_ready;
    end

    // Next-state: independent drains on all channels, then the accepted
    // beat (if any) overrides the drain on its target channel.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        for (int k = 0; k < 4; k++) begin
            if (valid_q[k] && out_ready[k]) begin
                valid_d[k] = 1'b0;
            end
        end
        if (accept) begin
            valid_d[tgt] = 1'b1;
            data_d[tgt]  = in_data;
            cnt_d        = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (mode) begin
                rr_d = next_ptr(rr_q);
            end
        end
    end

    // State registers; reset discards buffered beats and clears payloads.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 4'b0000;
            rr_q    <= 2'd0;
            cnt_q   <= '0;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data0 = data_q[0];
    assign out_data1 = data_q[1];
    assign out_data2 = data_q[2];
    assign out_data3 = data_q[3];
    assign rr_ptr    = rr_q;
    assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_demux1to4_stream_ctrl.sv
// Directed testbench for demux1to4_stream_ctrl. A second instance with a
// 4-bit beat counter shares the same stimulus to exercise counter wrap.
module tb_demux1to4_stream_ctrl;

    logic       clk;
    logic       rst;
    logic       mode;
    logic       in_valid;
    logic [7:0] in_data;
    logic [1:0] in_dest;
    logic [3:0] out_ready;

    logic        in_ready;
    logic [3:0]  out_valid;
    logic [7:0]  od0, od1, od2, od3;
    logic [1:0]  rr_ptr;
    logic [15:0] beat_cnt;

    logic        in_ready_w;
    logic [3:0]  out_valid_w;
    logic [7:0]  wd0, wd1, wd2, wd3;
    logic [1:0]  rr_ptr_w;
    logic [3:0]  beat_cnt_w;

    logic [7:0]  od [4];
    assign od[0] = od0;
    assign od[1] = od1;
    assign od[2] = od2;
    assign od[3] = od3;

    int checks = 0;
    int errors = 0;

    demux1to4_stream_ctrl #(.DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_dest(in_dest),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data0(od0), .out_data1(od1), .out_data2(od2), .out_data3(od3),
        .rr_ptr(rr_ptr), .beat_cnt(beat_cnt)
    );

    demux1to4_stream_ctrl #(.DATA_W(8), .CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready_w),
        .in_data(in_data), .in_dest(in_dest),
        .out_valid(out_valid_w), .out_ready(out_ready),
        .out_data0(wd0), .out_data1(wd1), .out_data2(wd2), .out_data3(wd3),
        .rr_ptr(rr_ptr_w), .beat_cnt(beat_cnt_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid !== 4'b0000) begin
            errors++; $display("FAIL reset_valid got %b want 0000", out_valid);
        end
        checks++;
        if ({od0, od1, od2, od3} !== 32'h0) begin
            errors++; $display("FAIL reset_data got %h want 0", {od0, od1, od2, od3});
        end
        checks++;
        if (rr_ptr !== 2'd0 || beat_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_ptr_cnt got %0d/%0d want 0/0", rr_ptr, beat_cnt);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready got %b want 0", in_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_addressed();
        logic [7:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        mode = 1'b0;
        out_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = vals[i];
            in_dest  = 2'(i);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL addr_in_ready[%0d] got %b want 1", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 4'(1 << i)) begin
                errors++; $display("FAIL addr_valid[%0d] got %b want %b", i, out_valid, 4'(1 << i));
            end
        end
        in_valid = 1'b0;
        checks++;
        if (od0 !== 8'h11 || od1 !== 8'h22 || od2 !== 8'h33 || od3 !== 8'h44) begin
            errors++; $display("FAIL addr_data got %h %h %h %h want 11 22 33 44", od0, od1, od2, od3);
        end
        checks++;
        if (beat_cnt !== 16'd4) begin
            errors++; $display("FAIL addr_cnt got %0d want 4", beat_cnt);
        end
        checks++;
        if (rr_ptr !== 2'd0) begin
            errors++; $display("FAIL addr_rr_fixed got %0d want 0", rr_ptr);
        end
        tick();
        checks++;
        if (out_valid !== 4'b0000 || od3 !== 8'h44) begin
            errors++; $display("FAIL addr_drain got %b/%h want 0000/44", out_valid, od3);
        end
    endtask

    task automatic test_backpressure();
        mode = 1'b0;
        out_ready = 4'b0000;
        in_dest = 2'd2;
        in_valid = 1'b1;
        in_data = 8'hA5;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_first_ready got %b want 1", in_ready);
        end
        tick();
        in_data = 8'h5A;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_stall_ready got %b want 0", in_ready);
        end
        tick();
        checks++;
        if (od2 !== 8'hA5 || out_valid !== 4'b0100 || beat_cnt !== 16'd5) begin
            errors++; $display("FAIL bp_hold got %h/%b/%0d want a5/0100/5", od2, out_valid, beat_cnt);
        end
        out_ready = 4'b0100;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release_ready got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        out_ready = 4'b0000;
        checks++;
        if (od2 !== 8'h5A || out_valid !== 4'b0100 || beat_cnt !== 16'd6) begin
            errors++; $display("FAIL bp_refill got %h/%b/%0d want 5a/0100/6", od2, out_valid, beat_cnt);
        end
        out_ready = 4'b1111;
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        mode = 1'b1;
        out_ready = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data = 8'(i + 1);
            in_dest = 2'd3;
            #1;
            checks++;
            if (in_ready !== 1'b1 || rr_ptr !== 2'(i % 4)) begin
                errors++; $display("FAIL rr_pre[%0d] got %b/%0d want 1/%0d", i, in_ready, rr_ptr, i % 4);
            end
            tick();
            checks++;
            if (out_valid !== 4'(1 << (i % 4)) || od[i % 4] !== 8'(i + 1)) begin
                errors++; $display("FAIL rr_beat[%0d] got %b/%h want %b/%h", i, out_valid, od[i % 4], 4'(1 << (i % 4)), 8'(i + 1));
            end
        end
        in_valid = 1'b0;
        checks++;
        if (rr_ptr !== 2'd0 || beat_cnt !== 16'd8) begin
            errors++; $display("FAIL rr_end got %0d/%0d want 0/8", rr_ptr, beat_cnt);
        end
    endtask

    task automatic test_rr_stall();
        logic [7:0] vals [5];
        vals[0] = 8'h10; vals[1] = 8'h20; vals[2] = 8'h30; vals[3] = 8'h40; vals[4] = 8'h50;
        do_reset();
        mode = 1'b1;
        out_ready = 4'b1101;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data = vals[i];
            tick();
        end
        in_data = 8'h60;
        #1;
        checks++;
        if (in_ready !== 1'b0 || rr_ptr !== 2'd1) begin
            errors++; $display("FAIL rrs_stall got %b/%0d want 0/1", in_ready, rr_ptr);
        end
        tick();
        checks++;
        if (rr_ptr !== 2'd1 || od1 !== 8'h20 || beat_cnt !== 16'd5) begin
            errors++; $display("FAIL rrs_hold got %0d/%h/%0d want 1/20/5", rr_ptr, od1, beat_cnt);
        end
        out_ready = 4'b1111;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL rrs_release_ready got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (rr_ptr !== 2'd2 || od1 !== 8'h60 || out_valid[1] !== 1'b1 || beat_cnt !== 16'd6) begin
            errors++; $display("FAIL rrs_accept got %0d/%h/%b/%0d want 2/60/1/6", rr_ptr, od1, out_valid[1], beat_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mode = 1'b0;
        out_ready = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data = 8'hC0 + 8'(i);
            in_dest = 2'(i);
            tick();
        end
        out_ready = 4'b0001;
        in_dest = 2'd0;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'hD0 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 4'b0000;
        checks++;
        if (out_valid !== 4'b1111 || beat_cnt !== 16'd9 || od0 !== 8'hD4) begin
            errors++; $display("FAIL mid_pre got %b/%0d/%h want 1111/9/d4", out_valid, beat_cnt, od0);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL mid_in_ready got %b want 0", in_ready);
        end
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 4'b0000 || {od0, od1, od2, od3} !== 32'h0 || rr_ptr !== 2'd0 || beat_cnt !== 16'd0) begin
            errors++; $display("FAIL mid_post got %b/%h/%0d/%0d want 0000/0/0/0", out_valid, {od0, od1, od2, od3}, rr_ptr, beat_cnt);
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        mode = 1'b0;
        out_ready = 4'b1111;
        in_dest = 2'd0;
        for (int i = 1; i <= 17; i++) begin
            in_valid = 1'b1;
            in_data = 8'(i);
            tick();
            if (i == 15) begin
                checks++;
                if (beat_cnt_w !== 4'd15) begin
                    errors++; $display("FAIL wrap_15 got %0d want 15", beat_cnt_w);
                end
            end
            if (i == 16) begin
                checks++;
                if (beat_cnt_w !== 4'd0) begin
                    errors++; $display("FAIL wrap_16 got %0d want 0", beat_cnt_w);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (beat_cnt_w !== 4'd1) begin
            errors++; $display("FAIL wrap_17 got %0d want 1", beat_cnt_w);
        end
        checks++;
        if (beat_cnt !== 16'd17 || od0 !== 8'h11) begin
            errors++; $display("FAIL wrap_wide got %0d/%h want 17/11", beat_cnt, od0);
        end
    endtask

    initial begin
        rst = 1'b1;
        mode = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        in_dest = 2'd0;
        out_ready = 4'b0000;
        test_reset();
        test_addressed();
        test_backpressure();
        test_round_robin();
        test_rr_stall();
        test_reset_mid();
        test_counter_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
